// File: rtl/pipo_arb_pkg.sv
// Shared definitions for the PIPO load-scheduling arbiter and its datapath.
// Holds the FSM state encoding and default geometry constants.
package pipo_arb_pkg;

    localparam int unsigned PIPO_N_REQ       = 4;
    localparam int unsigned PIPO_WIDTH       = 4;
    localparam int unsigned PIPO_HOLD_CYCLES = 2;

    localparam int unsigned ST_W = 1;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request strictly after 'last', with wrap.
// Purely combinational; any_req flags that a winner exists.
module rr_priority_pick
    import pipo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = PIPO_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    int unsigned      w_idx;
    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    // Scan offsets 1..N_REQ so 'last' itself is visited last.
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_pos   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = (32'(last) + k) % N_REQ;
            w_pos = IDX_W'(w_idx);
            if (!w_found && req[w_pos]) begin
                winner  = w_pos;
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin scheduler loading one requester's word into a shared PIPO register,
// holding it valid for HOLD_CYCLES cycles before the next arbitration.
module pipo_rr_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = PIPO_N_REQ,
    parameter int unsigned WIDTH       = PIPO_WIDTH,
    parameter int unsigned HOLD_CYCLES = PIPO_HOLD_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data_in,
    output logic [N_REQ-1:0]         grant,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    output logic [$clog2(N_REQ)-1:0] out_owner,
    output logic                     busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (HOLD_CYCLES < 1) begin : g_hold_chk
        $error("pipo_rr_arbiter: HOLD_CYCLES must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_nreq_chk
        $error("pipo_rr_arbiter: N_REQ must be in 2..16");
    end

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [N_REQ-1:0] r_grant;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [IDX_W-1:0] w_winner;
    logic             w_any;
    logic [WIDTH-1:0] w_word;
    logic [N_REQ-1:0] w_onehot;
    logic             w_load;
    logic             w_hold_done;
    logic             w_busy;

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req),
        .last    (r_last),
        .winner  (w_winner),
        .any_req (w_any)
    );

    always_comb begin
        w_word   = '0;
        w_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == w_winner) begin
                w_word      = data_in[i*WIDTH +: WIDTH];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_next = ST_HOLD;
            ST_HOLD: if (r_hold_cnt == '0) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_load      = (r_state == ST_IDLE) && w_any;
        w_hold_done = (r_state == ST_HOLD) && (r_hold_cnt == '0);
    end

    // Data register only loads on the IDLE->HOLD transition, so data_in is ignored otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_owner    <= '0;
            r_last     <= IDX_W'(N_REQ - 1);
            r_hold_cnt <= '0;
        end else begin
            r_grant <= '0;
            if (w_load) begin
                r_grant    <= w_onehot;
                r_data     <= w_word;
                r_valid    <= 1'b1;
                r_owner    <= w_winner;
                r_last     <= w_winner;
                r_hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
            end else if (w_hold_done) begin
                r_valid <= 1'b0;
            end else if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt - CNT_W'(1);
            end
        end
    end

    assign grant     = r_grant;
    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign out_owner = r_owner;
    assign busy      = w_busy;

endmodule
